ddr4_init_sequencer: RTL and testbench

- Controller-side generator of the DDR4 power-up/initialization sequence.
- Drives the DRAM reset, CKE and command pins, then pulses the control-interface strobes mrs_rdy and zqcl_rdy and raises config_done.
- Sits between the controller top level and the DDR/CTRL interfaces.
- Its output timing must satisfy the team's reset/initialization timing checker exactly at the minimum legal spacing.

---
 rtl/ddr4_init_sequencer_if.sv | 32 +++
 rtl/ddr4_init_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_ddr4_init_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ddr4_init_sequencer_if.sv
// Pin bundle between the DDR4 init sequencer and the controller top / DRAM pads.
// The sequencer takes the master side; the controller/bench takes the slave side.
interface ddr4_init_sequencer_if;
  logic        start;
  logic [97:0] mr_values;
  logic        ddr_reset_n;
  logic        cke;
  logic        cs_n;
  logic        act_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic [13:0] addr;
  logic        mrs_rdy;
  logic        zqcl_rdy;
  logic        config_done;
  logic        busy;

  modport master (
    input  start, mr_values,
    output ddr_reset_n, cke, cs_n, act_n, ras_n, cas_n, we_n,
           bg, ba, addr, mrs_rdy, zqcl_rdy, config_done, busy
  );

  modport slave (
    output start, mr_values,
    input  ddr_reset_n, cke, cs_n, act_n, ras_n, cas_n, we_n,
           bg, ba, addr, mrs_rdy, zqcl_rdy, config_done, busy
  );
endinterface

// File: rtl/ddr4_init_sequencer.sv
// DDR4 power-up sequencer: RESET_n/CKE ramp, seven MRS writes, ZQCL, then config_done.
// Every pin is registered; events land exactly N rising edges after their source edge.
module ddr4_init_sequencer #(
  parameter int T_RESET = 16,
  parameter int T_CKE_L = 10,
  parameter int T_XPR   = 12,
  parameter int T_MRD   = 8,
  parameter int T_MOD   = 24,
  parameter int T_ZQ    = 512
) (
  input  logic                  clock_t,
  input  logic                  reset_n,
  ddr4_init_sequencer_if.master bus
);

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = imax(imax(imax(T_RESET, T_CKE_L), imax(T_XPR, T_MRD)), imax(T_MOD, T_ZQ));
  localparam int CW   = $clog2(TMAX) + 1;

  if (T_RESET < 2 || T_CKE_L < 2 || T_XPR < 2 || T_MRD < 2 || T_MOD < 2 || T_ZQ < 2) begin : g_bad_param
    $error("ddr4_init_sequencer: all timing parameters must be >= 2");
  end

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RST_HOLD = 4'd1;
  localparam logic [3:0] S_CKE_WAIT = 4'd2;
  localparam logic [3:0] S_XPR_WAIT = 4'd3;
  localparam logic [3:0] S_MRS      = 4'd4;
  localparam logic [3:0] S_MRD_WAIT = 4'd5;
  localparam logic [3:0] S_MOD_WAIT = 4'd6;
  localparam logic [3:0] S_ZQCL     = 4'd7;
  localparam logic [3:0] S_ZQ_WAIT  = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  // JEDEC-recommended MR programming order, indexed by issue slot.
  function automatic logic [2:0] mr_num(logic [2:0] idx);
    case (idx)
      3'd0:    return 3'd3;
      3'd1:    return 3'd6;
      3'd2:    return 3'd5;
      3'd3:    return 3'd4;
      3'd4:    return 3'd2;
      3'd5:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          rstn_q, rstn_d;
  logic          cke_q, cke_d;
  logic [4:0]    cmd_q, cmd_d;   // {cs_n, act_n, ras_n, cas_n, we_n}
  logic [1:0]    bg_q, bg_d;
  logic [1:0]    ba_q, ba_d;
  logic [13:0]   addr_q, addr_d;
  logic          mrs_q, mrs_d;
  logic          zq_q, zq_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [2:0]    mrn;

  assign mrn = mr_num(idx_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    idx_d   = idx_q;
    rstn_d  = rstn_q;
    cke_d   = cke_q;
    done_d  = done_q;
    cmd_d   = 5'b11111;
    bg_d    = 2'b00;
    ba_d    = 2'b00;
    addr_d  = 14'd0;
    mrs_d   = 1'b0;
    zq_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RST_HOLD;
          cnt_d   = CW'(T_RESET - 1);
          idx_d   = 3'd0;
          rstn_d  = 1'b0;
          cke_d   = 1'b0;
          done_d  = 1'b0;
        end
      end
      S_RST_HOLD: if (cnt_q == '0) begin
        state_d = S_CKE_WAIT;
        cnt_d   = CW'(T_CKE_L - 1);
        rstn_d  = 1'b1;
      end
      S_CKE_WAIT: if (cnt_q == '0) begin
        state_d = S_XPR_WAIT;
        cnt_d   = CW'(T_XPR - 1);
        cke_d   = 1'b1;
      end
      S_XPR_WAIT, S_MRD_WAIT: if (cnt_q == '0) begin
        state_d = S_MRS;
        cmd_d   = 5'b01000;
        bg_d    = {1'b0, mrn[2]};
        ba_d    = mrn[1:0];
        addr_d  = bus.mr_values[mrn*14 +: 14];
        mrs_d   = 1'b1;
      end
      // The command cycle itself counts toward the following gap, hence the -2 loads.
      S_MRS: begin
        if (idx_q == 3'd6) begin
          state_d = S_MOD_WAIT;
          cnt_d   = CW'(T_MOD - 2);
        end else begin
          state_d = S_MRD_WAIT;
          cnt_d   = CW'(T_MRD - 2);
          idx_d   = idx_q + 3'd1;
        end
      end
      S_MOD_WAIT: if (cnt_q == '0) begin
        state_d = S_ZQCL;
        cmd_d   = 5'b01110;
        addr_d  = 14'h0400;
        zq_d    = 1'b1;
      end
      S_ZQCL: begin
        state_d = S_ZQ_WAIT;
        cnt_d   = CW'(T_ZQ - 2);
      end
      S_ZQ_WAIT: if (cnt_q == '0) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
        rstn_d  = 1'b0;
        cke_d   = 1'b0;
        done_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      rstn_q  <= 1'b0;
      cke_q   <= 1'b0;
      cmd_q   <= 5'b11111;
      bg_q    <= 2'b00;
      ba_q    <= 2'b00;
      addr_q  <= 14'd0;
      mrs_q   <= 1'b0;
      zq_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      mrs_q   <= mrs_d;
      zq_q    <= zq_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ddr_reset_n = rstn_q;
  assign bus.cke         = cke_q;
  assign bus.cs_n        = cmd_q[4];
  assign bus.act_n       = cmd_q[3];
  assign bus.ras_n       = cmd_q[2];
  assign bus.cas_n       = cmd_q[1];
  assign bus.we_n        = cmd_q[0];
  assign bus.bg          = bg_q;
  assign bus.ba          = ba_q;
  assign bus.addr        = addr_q;
  assign bus.mrs_rdy     = mrs_q;
  assign bus.zqcl_rdy    = zq_q;
  assign bus.config_done = done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ddr4_init_sequencer.sv
// Bench for ddr4_init_sequencer: default and fast (T_MRD=T_ZQ=2) instances against an
// event-time reference model, with random start/MR payload traffic and a mid-sequence reset.
module tb_ddr4_init_sequencer;
  localparam int T_RESET = 16;
  localparam int T_CKE_L = 10;
  localparam int T_XPR   = 12;
  localparam int T_MOD   = 24;
  localparam logic [28:0] RST_VEC = {2'b00, 5'b11111, 2'b00, 2'b00, 14'd0, 4'b0000};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [97:0] mr_values;
  logic [97:0] mr_snap;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit   [1:0]  act = 2'b00;
  int          e0 [2];
  int          tmrd [2];
  int          tzq [2];
  int          order [7];

  always #5 clk = ~clk;

  ddr4_init_sequencer_if ia ();
  ddr4_init_sequencer_if ib ();
  assign ia.start = start;
  assign ib.start = start;
  assign ia.mr_values = mr_values;
  assign ib.mr_values = mr_values;

  ddr4_init_sequencer u_a (.clock_t(clk), .reset_n(reset_n), .bus(ia.master));
  ddr4_init_sequencer #(.T_MRD(2), .T_ZQ(2)) u_b (.clock_t(clk), .reset_n(reset_n), .bus(ib.master));

  logic [28:0] obs_a, obs_b;
  assign obs_a = {ia.ddr_reset_n, ia.cke, ia.cs_n, ia.act_n, ia.ras_n, ia.cas_n, ia.we_n,
                  ia.bg, ia.ba, ia.addr, ia.mrs_rdy, ia.zqcl_rdy, ia.config_done, ia.busy};
  assign obs_b = {ib.ddr_reset_n, ib.cke, ib.cs_n, ib.act_n, ib.ras_n, ib.cas_n, ib.we_n,
                  ib.bg, ib.ba, ib.addr, ib.mrs_rdy, ib.zqcl_rdy, ib.config_done, ib.busy};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int tot(input int i);
    return T_RESET + T_CKE_L + T_XPR + 6 * tmrd[i] + T_MOD + tzq[i];
  endfunction

  // Expected pins d edges after the start-sampling edge, from absolute event times.
  function automatic logic [28:0] exp_out(input bit a, input int d, input int i, input logic [97:0] mr);
    logic rn, ck, cs, ac, ra, ca, we, mrs, zq, cd, bsy;
    logic [1:0] g, b;
    logic [13:0] ad;
    int r, k, x, z, n;
    {rn, ck, mrs, zq, cd, bsy} = '0;
    {cs, ac, ra, ca, we} = 5'b11111;
    g = 2'b00; b = 2'b00; ad = 14'd0;
    if (a) begin
      r = T_RESET; k = r + T_CKE_L; x = k + T_XPR; z = x + 6 * tmrd[i] + T_MOD;
      rn = (d >= r); ck = (d >= k); cd = (d >= z + tzq[i]); bsy = (d < z + tzq[i]);
      for (int m = 0; m < 7; m++) begin
        if (d == x + m * tmrd[i]) begin
          n = order[m];
          {cs, ra, ca, we} = 4'b0000; mrs = 1'b1;
          g = {1'b0, n[2]}; b = n[1:0]; ad = mr[n*14 +: 14];
        end
      end
      if (d == z) begin
        cs = 1'b0; we = 1'b0; zq = 1'b1; ad = 14'h0400;
      end
    end
    return {rn, ck, cs, ac, ra, ca, we, g, b, ad, mrs, zq, cd, bsy};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act <= 2'b00;
    end else begin
      cyc <= cyc + 1;
      mr_snap <= mr_values;
      for (int i = 0; i < 2; i++) begin
        if (start && !(act[i] && (cyc - e0[i]) < tot(i))) begin
          act[i] <= 1'b1;
          e0[i]  <= cyc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("pins_a", 32'(obs_a), 32'(exp_out(act[0], cyc - e0[0], 0, mr_snap)));
    chk("pins_b", 32'(obs_b), 32'(exp_out(act[1], cyc - e0[1], 1, mr_snap)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag, input int maxc, input bit rnd_mr);
    int n = 0;
    while (!ia.config_done && n < maxc) begin
      if (rnd_mr) mr_values = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    chk(tag, 32'(ia.config_done), 32'd1);
  endtask

  initial begin
    tmrd  = '{8, 2};
    tzq   = '{512, 2};
    order = '{3, 6, 5, 4, 2, 1, 0};
    e0    = '{0, 0};
    reset_n = 1'b0;
    start = 1'b0;
    for (int n = 0; n < 7; n++) mr_values[n*14 +: 14] = 14'h1000 + 14'(n);
    mr_snap = mr_values;
    repeat (3) tick();
    reset_n = 1'b1;
    chk("rst_a", 32'(obs_a), 32'(RST_VEC));
    chk("rst_b", 32'(obs_b), 32'(RST_VEC));
    tick();

    // Fixed MR payloads, single start pulse, stray starts while busy.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 700 && !ia.config_done; n++) begin
      start = ($urandom_range(0, 9) == 0) && ia.busy;
      tick();
    end
    start = 1'b0;
    chk("done1_a", 32'(ia.config_done), 32'd1);
    repeat (4) tick();
    chk("hold_done_a", 32'(ia.config_done), 32'd1);

    // start held high: back-to-back sequences with random payloads every cycle.
    start = 1'b1;
    for (int n = 0; n < 1400; n++) begin
      mr_values = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    start = 1'b0;
    wait_done("done2_a", 800, 1'b1);

    // Abort with async reset in the gap after the third MRS.
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      int seen = 0;
      int n = 0;
      while (seen < 3 && n < 200) begin
        mr_values = {$urandom, $urandom, $urandom, $urandom};
        tick();
        if (ia.mrs_rdy) seen++;
        n++;
      end
      chk("three_mrs", 32'(seen), 32'd3);
    end
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_a", 32'(obs_a), 32'(RST_VEC));
    chk("async_rst_b", 32'(obs_b), 32'(RST_VEC));
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("done3_a", 800, 1'b1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
